// File: rtl/spi_ram_pkg.sv
// Shared types for the two-requester SPI RAM arbiter: command opcodes, arbiter states and
// the default RAM address width.
package spi_ram_pkg;

    parameter int unsigned AddrSizeDefault = 8;

    typedef enum logic [1:0] {
        WrAddr = 2'b00,
        WrData = 2'b01,
        RdAddr = 2'b10,
        RdData = 2'b11
    } spi_op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StIssue  = 2'b01,
        StRdWait = 2'b10
    } arb_state_e;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Bundle of requester command/response signals and the shared RAM port.
// The slave modport is the arbiter's view; master is the environment (SPI slaves + RAM).
interface spi_ram_arbiter_if
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = AddrSizeDefault
) ();

    logic [9:0]           rx_data_0;
    logic [9:0]           rx_data_1;
    logic                 rx_valid_0;
    logic                 rx_valid_1;
    logic [7:0]           tx_data_0;
    logic [7:0]           tx_data_1;
    logic                 tx_valid_0;
    logic                 tx_valid_1;
    logic                 ovf_0;
    logic                 ovf_1;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [7:0]           mem_wdata;
    logic                 mem_we;
    logic                 mem_re;
    logic [7:0]           mem_rdata;

    modport slave (
        input  rx_data_0, rx_data_1, rx_valid_0, rx_valid_1, mem_rdata,
        output tx_data_0, tx_data_1, tx_valid_0, tx_valid_1, ovf_0, ovf_1,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output rx_data_0, rx_data_1, rx_valid_0, rx_valid_1, mem_rdata,
        input  tx_data_0, tx_data_1, tx_valid_0, tx_valid_1, ovf_0, ovf_1,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );

endinterface

// File: rtl/spi_req_port.sv
// Per-requester state: address registers, one-entry pending buffer, sticky overflow flag and
// the read-response hold counter.
module spi_req_port
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = AddrSizeDefault,
    parameter int unsigned TX_HOLD   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           rx_data_i,
    input  logic                 rx_valid_i,
    input  logic                 clr_pend_i,
    input  logic                 load_tx_i,
    input  logic [7:0]           mem_rdata_i,
    output logic                 pend_o,
    output logic                 pend_rd_o,
    output logic [7:0]           pend_wdata_o,
    output logic [ADDR_SIZE-1:0] wr_addr_o,
    output logic [ADDR_SIZE-1:0] rd_addr_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    output logic                 ovf_o
);

    localparam int unsigned CntW = $clog2(TX_HOLD + 1);

    spi_op_e              op;
    logic [7:0]           payload;
    logic                 pend_q, pend_d;
    logic                 pend_rd_q, pend_rd_d;
    logic [7:0]           pend_wdata_q, pend_wdata_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    assign op      = spi_op_e'(rx_data_i[9:8]);
    assign payload = rx_data_i[7:0];

    always_comb begin
        pend_d       = pend_q & ~clr_pend_i;
        pend_rd_d    = pend_rd_q;
        pend_wdata_d = pend_wdata_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        tx_data_d    = tx_data_q;
        ovf_d        = ovf_q;
        cnt_d        = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;

        if (rx_valid_i) begin
            unique case (op)
                WrAddr: wr_addr_d = ADDR_SIZE'(payload);
                RdAddr: rd_addr_d = ADDR_SIZE'(payload);
                WrData, RdData: begin
                    // A strobe on the clearing edge refills the slot instead of overflowing.
                    if (pend_q && !clr_pend_i) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_d       = 1'b1;
                        pend_rd_d    = (op == RdData);
                        pend_wdata_d = payload;
                    end
                end
                default: ;
            endcase
        end

        if (load_tx_i) begin
            tx_data_d = mem_rdata_i;
            cnt_d     = CntW'(TX_HOLD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= 1'b0;
            pend_rd_q    <= 1'b0;
            pend_wdata_q <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            tx_data_q    <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pend_rd_q    <= pend_rd_d;
            pend_wdata_q <= pend_wdata_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            tx_data_q    <= tx_data_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign pend_o       = pend_q;
    assign pend_rd_o    = pend_rd_q;
    assign pend_wdata_o = pend_wdata_q;
    assign wr_addr_o    = wr_addr_q;
    assign rd_addr_o    = rd_addr_q;
    assign tx_data_o    = tx_data_q;
    assign tx_valid_o   = (cnt_q != '0);
    assign ovf_o        = ovf_q;

endmodule

// File: rtl/spi_ram_arbiter.sv
// Two-requester arbiter sharing one RAM port. Round-robin on ties by default; define
// SPI_ARB_FIXED_PRIO_EN to make requester 0 always win ties.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = AddrSizeDefault,
    parameter int unsigned TX_HOLD   = 8
) (
    input logic              clk,
    input logic              rst,
    spi_ram_arbiter_if.slave bus
);

    logic [9:0]           rx_data [2];
    logic [1:0]           rx_valid;
    logic [1:0]           pend, pend_rd, clr_pend, load_tx, tx_valid, ovf;
    logic [7:0]           pend_wdata [2];
    logic [ADDR_SIZE-1:0] wr_addr [2];
    logic [ADDR_SIZE-1:0] rd_addr [2];
    logic [7:0]           tx_data [2];

    assign rx_data[0]  = bus.rx_data_0;
    assign rx_data[1]  = bus.rx_data_1;
    assign rx_valid[0] = bus.rx_valid_0;
    assign rx_valid[1] = bus.rx_valid_1;

    for (genvar i = 0; i < 2; i++) begin : g_port
        spi_req_port #(
            .ADDR_SIZE(ADDR_SIZE),
            .TX_HOLD  (TX_HOLD)
        ) u_port (
            .clk         (clk),
            .rst         (rst),
            .rx_data_i   (rx_data[i]),
            .rx_valid_i  (rx_valid[i]),
            .clr_pend_i  (clr_pend[i]),
            .load_tx_i   (load_tx[i]),
            .mem_rdata_i (bus.mem_rdata),
            .pend_o      (pend[i]),
            .pend_rd_o   (pend_rd[i]),
            .pend_wdata_o(pend_wdata[i]),
            .wr_addr_o   (wr_addr[i]),
            .rd_addr_o   (rd_addr[i]),
            .tx_data_o   (tx_data[i]),
            .tx_valid_o  (tx_valid[i]),
            .ovf_o       (ovf[i])
        );
    end

    arb_state_e           state_q, state_d;
    logic                 last_q, last_d;
    logic                 gnt_q, gnt_d;
    logic                 pick;
    logic                 mem_we_q, mem_we_d;
    logic                 mem_re_q, mem_re_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;

    always_comb begin
`ifdef SPI_ARB_FIXED_PRIO_EN
        pick = ~pend[0];
`else
        if (&pend) begin
            pick = ~last_q;
        end else begin
            pick = ~pend[0];
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        clr_pend    = 2'b00;
        load_tx     = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (|pend) begin
                    state_d        = StIssue;
                    gnt_d          = pick;
                    last_d         = pick;
                    clr_pend[pick] = 1'b1;
                    mem_we_d       = ~pend_rd[pick];
                    mem_re_d       = pend_rd[pick];
                    if (pend_rd[pick]) begin
                        mem_addr_d = rd_addr[pick];
                    end else begin
                        mem_addr_d  = wr_addr[pick];
                        mem_wdata_d = pend_wdata[pick];
                    end
                end
            end
            StIssue:  state_d = mem_re_q ? StRdWait : StIdle;
            StRdWait: begin
                state_d        = StIdle;
                load_tx[gnt_q] = 1'b1;
            end
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.tx_data_0  = tx_data[0];
    assign bus.tx_data_1  = tx_data[1];
    assign bus.tx_valid_0 = tx_valid[0];
    assign bus.tx_valid_1 = tx_valid[1];
    assign bus.ovf_0      = ovf[0];
    assign bus.ovf_1      = ovf[1];

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter: expected RAM operations and read responses are queued
// as commands are driven and compared when the arbiter produces them.
module tb_spi_ram_arbiter;
    import spi_ram_pkg::*;

    localparam int TxHold = 8;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } mem_op_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    mem_op_t    exp_mem_q [$];
    logic [7:0] exp_tx0_q [$];
    logic [7:0] exp_tx1_q [$];
    logic [7:0] ram [256];

    spi_ram_arbiter_if #(.ADDR_SIZE(8)) bus ();

    spi_ram_arbiter #(
        .ADDR_SIZE(8),
        .TX_HOLD  (TxHold)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data appears one cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Mem-port monitor.
    int n_we = 0;
    int mem_cyc = 0;
    always @(negedge clk) begin : mon_mem
        mem_op_t e;
        if (bus.mem_we || bus.mem_re) begin
            mem_cyc <= cyc;
            n_we    <= n_we + int'(bus.mem_we);
            if (exp_mem_q.size() == 0) begin
                check("mem_unexpected", 1, 0);
            end else begin
                e = exp_mem_q.pop_front();
                check("mem_we", int'(bus.mem_we), int'(e.we));
                check("mem_re", int'(bus.mem_re), int'(!e.we));
                check("mem_addr", int'(bus.mem_addr), int'(e.addr));
                if (e.we) check("mem_wdata", int'(bus.mem_wdata), int'(e.wdata));
            end
        end
    end

    // Read-response monitor.
    logic [1:0] tv_prev = 2'b00;
    int         run_len [2] = '{0, 0};
    logic [7:0] held [2];
    int         n_rise [2] = '{0, 0};
    int         rise_cyc [2] = '{0, 0};
    always @(negedge clk) begin : mon_tx
        logic       v;
        logic [7:0] d;
        logic [7:0] e;
        for (int r = 0; r < 2; r++) begin
            v = (r == 0) ? bus.tx_valid_0 : bus.tx_valid_1;
            d = (r == 0) ? bus.tx_data_0 : bus.tx_data_1;
            if (v && !tv_prev[r]) begin
                n_rise[r]   <= n_rise[r] + 1;
                rise_cyc[r] <= cyc;
                run_len[r]  <= 1;
                held[r]     <= d;
                if ((r == 0 ? exp_tx0_q.size() : exp_tx1_q.size()) == 0) begin
                    check("tx_unexpected", r, -1);
                end else begin
                    e = (r == 0) ? exp_tx0_q.pop_front() : exp_tx1_q.pop_front();
                    check("tx_data", int'(d), int'(e));
                end
            end else if (v) begin
                run_len[r] <= run_len[r] + 1;
                if (d !== held[r]) check("tx_stable", int'(d), int'(held[r]));
            end else if (tv_prev[r]) begin
                check("tx_hold_len", run_len[r], TxHold);
            end
            tv_prev[r] <= v;
        end
    end

    function automatic logic [9:0] cmd(input spi_op_e op, input logic [7:0] pl);
        return {op, pl};
    endfunction

    task automatic exp_op(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        mem_op_t e;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        exp_mem_q.push_back(e);
    endtask

    // Called at a negedge; the command is sampled on the following posedge.
    task automatic drive(input logic v0, input logic [9:0] d0, input logic v1,
                         input logic [9:0] d1);
        bus.rx_valid_0 = v0;
        bus.rx_data_0  = d0;
        bus.rx_valid_1 = v1;
        bus.rx_data_1  = d1;
        @(negedge clk);
        bus.rx_valid_0 = 1'b0;
        bus.rx_valid_1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int we0;
        rst            = 1'b1;
        bus.rx_valid_0 = 1'b0;
        bus.rx_valid_1 = 1'b0;
        bus.rx_data_0  = '0;
        bus.rx_data_1  = '0;
        repeat (3) @(negedge clk);

        check("rst_tx_valid_0", int'(bus.tx_valid_0), 0);
        check("rst_tx_valid_1", int'(bus.tx_valid_1), 0);
        check("rst_ovf_0", int'(bus.ovf_0), 0);
        check("rst_ovf_1", int'(bus.ovf_1), 0);
        check("rst_mem_we", int'(bus.mem_we), 0);
        check("rst_mem_re", int'(bus.mem_re), 0);
        check("rst_mem_addr", int'(bus.mem_addr), 0);
        check("rst_tx_data_0", int'(bus.tx_data_0), 0);
        check("rst_state", int'(dut.state_q), int'(StIdle));
        check("rst_last", int'(dut.last_q), 1);
        rst = 1'b0;
        @(negedge clk);

        // Single write from requester 0.
        drive(1'b1, cmd(WrAddr, 8'h10), 1'b0, '0);
        we0 = n_we;
        exp_op(1'b1, 8'h10, 8'hA5);
        drive(1'b1, cmd(WrData, 8'hA5), 1'b0, '0);
        t0 = cyc;
        repeat (6) @(negedge clk);
        check("wr_latency", mem_cyc - t0, 1);
        check("wr_count", n_we - we0, 1);

        // Read-back by requester 1.
        drive(1'b0, '0, 1'b1, cmd(RdAddr, 8'h10));
        exp_op(1'b0, 8'h10, 8'h00);
        exp_tx1_q.push_back(8'hA5);
        drive(1'b0, '0, 1'b1, cmd(RdData, 8'h00));
        t0 = cyc;
        repeat (14) @(negedge clk);
        check("rd_latency", rise_cyc[1] - t0, 3);
        check("rd_tx1_count", n_rise[1], 1);
        check("rd_tx0_quiet", n_rise[0], 0);

        // Two simultaneous write pairs; last grant is requester 1, so 0 goes first each time.
        drive(1'b1, cmd(WrAddr, 8'h20), 1'b1, cmd(WrAddr, 8'h30));
        exp_op(1'b1, 8'h20, 8'h11);
        exp_op(1'b1, 8'h30, 8'h22);
        drive(1'b1, cmd(WrData, 8'h11), 1'b1, cmd(WrData, 8'h22));
        repeat (6) @(negedge clk);
        exp_op(1'b1, 8'h20, 8'h33);
        exp_op(1'b1, 8'h30, 8'h44);
        drive(1'b1, cmd(WrData, 8'h33), 1'b1, cmd(WrData, 8'h44));
        repeat (6) @(negedge clk);

        // Lone requester-0 write, then a tie: round-robin now favours requester 1.
        exp_op(1'b1, 8'h20, 8'h55);
        drive(1'b1, cmd(WrData, 8'h55), 1'b0, '0);
        repeat (4) @(negedge clk);
`ifdef SPI_ARB_FIXED_PRIO_EN
        exp_op(1'b1, 8'h20, 8'h66);
        exp_op(1'b1, 8'h30, 8'h77);
`else
        exp_op(1'b1, 8'h30, 8'h77);
        exp_op(1'b1, 8'h20, 8'h66);
`endif
        drive(1'b1, cmd(WrData, 8'h66), 1'b1, cmd(WrData, 8'h77));
        repeat (6) @(negedge clk);
        check("tie_q_drained", exp_mem_q.size(), 0);

        // Requester 1 holds the grant while requester 0 strobes twice; the second is dropped.
        we0 = n_we;
        exp_op(1'b0, 8'h10, 8'h00);
        exp_tx1_q.push_back(8'hA5);
        drive(1'b0, '0, 1'b1, cmd(RdData, 8'h00));
        exp_op(1'b1, 8'h20, 8'h99);
        drive(1'b1, cmd(WrData, 8'h99), 1'b0, '0);
        drive(1'b1, cmd(WrData, 8'h9A), 1'b0, '0);
        repeat (14) @(negedge clk);
        check("ovf_0_set", int'(bus.ovf_0), 1);
        check("ovf_1_clear", int'(bus.ovf_1), 0);
        check("ovf_one_write", n_we - we0, 1);
        check("ovf_tx1_count", n_rise[1], 2);

        // Reset while the read sits in RD_WAIT.
        drive(1'b1, cmd(RdAddr, 8'h20), 1'b0, '0);
        exp_op(1'b0, 8'h20, 8'h00);
        drive(1'b1, cmd(RdData, 8'h00), 1'b0, '0);
        repeat (2) @(negedge clk);
        check("pre_rst_state", int'(dut.state_q), int'(StRdWait));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx_valid_0", int'(bus.tx_valid_0), 0);
        check("abort_mem_re", int'(bus.mem_re), 0);
        check("abort_state", int'(dut.state_q), int'(StIdle));
        check("abort_pend_0", int'(dut.g_port[0].u_port.pend_q), 0);
        check("abort_pend_1", int'(dut.g_port[1].u_port.pend_q), 0);
        check("abort_ovf_0", int'(bus.ovf_0), 0);
        repeat (4) @(negedge clk);
        check("abort_no_tx0", n_rise[0], 0);

        // A read after the abort completes normally.
        drive(1'b1, cmd(RdAddr, 8'h30), 1'b0, '0);
        exp_op(1'b0, 8'h30, 8'h00);
        exp_tx0_q.push_back(8'h77);
        drive(1'b1, cmd(RdData, 8'h00), 1'b0, '0);
        t0 = cyc;
        repeat (14) @(negedge clk);
        check("recover_tx0_count", n_rise[0], 1);
        check("recover_latency", rise_cyc[0] - t0, 3);

        check("mem_q_empty", exp_mem_q.size(), 0);
        check("tx0_q_empty", exp_tx0_q.size(), 0);
        check("tx1_q_empty", exp_tx1_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
